// File: rtl/map_ss_seq.sv
`default_nettype none
// ============================================================================
// Module : map_ss_seq
// Save-state sequencer: copies mapper registers to the host state buffer
// (save) or writes them back across one falling m2 edge each (load).
// Rev    : 1.0
// ============================================================================
module map_ss_seq #(
    parameter int SS_REGS    = 128,
    parameter int SETTLE     = 2,
    parameter int M2_TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m2,
    input  logic       start,
    input  logic       dir,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_dat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] buf_addr,
    output logic       buf_we,
    output logic [7:0] buf_wdat,
    input  logic [7:0] buf_rdat
);

    localparam int c_TMO_W = $clog2(M2_TIMEOUT + 1);
    localparam int c_SET_W = $clog2(SETTLE + 1);
    localparam int c_CNT_W = (c_TMO_W > c_SET_W) ? c_TMO_W : c_SET_W;

    localparam logic [c_CNT_W-1:0] c_SET_LAST = c_CNT_W'(SETTLE - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(M2_TIMEOUT - 1);
    localparam logic [7:0]         c_IDX_LAST = 8'(SS_REGS - 1);

    localparam logic [3:0] c_ST_IDLE     = 4'd0;
    localparam logic [3:0] c_ST_SV_WAIT  = 4'd1;
    localparam logic [3:0] c_ST_SV_CAP   = 4'd2;
    localparam logic [3:0] c_ST_LD_FETCH = 4'd3;
    localparam logic [3:0] c_ST_LD_LATCH = 4'd4;
    localparam logic [3:0] c_ST_LD_HI    = 4'd5;
    localparam logic [3:0] c_ST_LD_FALL  = 4'd6;
    localparam logic [3:0] c_ST_LD_NEXT  = 4'd7;
    localparam logic [3:0] c_ST_FIN      = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [7:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_m2_meta;
    logic               r_m2s;
    logic               r_m2s_d;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_ss_act;
    logic               r_ss_we;
    logic [7:0]         r_ss_dat;

    logic w_m2_fall;
    logic w_idx_last;
    logic w_tmo;

    assign w_m2_fall  = r_m2s_d & ~r_m2s;
    assign w_idx_last = (r_idx == c_IDX_LAST);
    assign w_tmo      = (r_cnt == c_TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next = dir ? c_ST_LD_FETCH : c_ST_SV_WAIT;
                end
            end
            c_ST_SV_WAIT: begin
                if (r_cnt == c_SET_LAST) begin
                    w_next = c_ST_SV_CAP;
                end
            end
            c_ST_SV_CAP:   w_next = w_idx_last ? c_ST_FIN : c_ST_SV_WAIT;
            c_ST_LD_FETCH: w_next = c_ST_LD_LATCH;
            c_ST_LD_LATCH: w_next = c_ST_LD_HI;
            c_ST_LD_HI: begin
                if (r_m2s) begin
                    w_next = c_ST_LD_FALL;
                end else if (w_tmo) begin
                    w_next = c_ST_FIN;
                end
            end
            c_ST_LD_FALL: begin
                if (w_m2_fall) begin
                    w_next = c_ST_LD_NEXT;
                end else if (w_tmo) begin
                    w_next = c_ST_FIN;
                end
            end
            c_ST_LD_NEXT:  w_next = w_idx_last ? c_ST_FIN : c_ST_LD_FETCH;
            c_ST_FIN:      w_next = c_ST_IDLE;
            default:       w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        buf_we   = 1'b0;
        buf_addr = 8'h00;
        buf_wdat = 8'h00;
        case (r_state)
            c_ST_SV_CAP: begin
                buf_we   = 1'b1;
                buf_addr = r_idx;
                buf_wdat = ss_rdat;
            end
            c_ST_LD_FETCH: buf_addr = r_idx;
            default: ;
        endcase
    end

    // The counter restarts on every state change, so it measures both the
    // settle time and the m2 wait of the current state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= 8'h00;
            r_cnt     <= '0;
            r_m2_meta <= 1'b0;
            r_m2s     <= 1'b0;
            r_m2s_d   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ss_act  <= 1'b0;
            r_ss_we   <= 1'b0;
            r_ss_dat  <= 8'h00;
        end else begin
            r_m2_meta <= m2;
            r_m2s     <= r_m2_meta;
            r_m2s_d   <= r_m2s;
            r_cnt     <= (w_next == r_state) ? r_cnt + 1'b1 : '0;
            r_done    <= (r_state == c_ST_FIN);
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_err    <= 1'b0;
                        r_idx    <= 8'h00;
                        r_ss_act <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                c_ST_SV_CAP: begin
                    if (!w_idx_last) begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                c_ST_LD_LATCH: r_ss_dat <= buf_rdat;
                c_ST_LD_HI: begin
                    if (r_m2s) begin
                        r_ss_we <= 1'b1;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                c_ST_LD_FALL: begin
                    if (w_m2_fall) begin
                        r_ss_we <= 1'b0;
                    end else if (w_tmo) begin
                        r_ss_we <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
                c_ST_LD_NEXT: begin
                    if (!w_idx_last) begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                c_ST_FIN: begin
                    r_ss_act <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign ss_act  = r_ss_act;
    assign ss_we   = r_ss_we;
    assign ss_dat  = r_ss_dat;
    assign ss_addr = r_ss_act ? r_idx : 8'h00;

endmodule
`default_nettype wire
